// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline constants and fetch state encoding
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0: the canonical bubble loaded into pipeline registers
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,  // nothing outstanding
    F_WAIT = 2'd1,  // one request outstanding, response wanted
    F_DROP = 2'd2   // one request outstanding, response is stale
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 1-entry pc/instr holding register between imem and IF/ID
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   wr_i               capture wr_pc_i/wr_instr_i (an accepted imem response)
//   drain_i            entry consumed by the IF/ID register this cycle
//   clear_i            discard the entry (redirect); wins over write and drain
//   valid_o            entry holds an undelivered instruction
//   pc_o, instr_o      held pc and instruction word
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            wr_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic [XLEN-1:0] wr_instr_i,
  input  logic            drain_i,
  input  logic            clear_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
      instr_o <= NOP_INSTR;
    end else begin
      if (clear_i) begin
        valid_o <= 1'b0;
      end else if (wr_i) begin
        // A write never meets a held entry unless that entry drains this cycle,
        // so write simply takes precedence over drain.
        valid_o <= 1'b1;
      end else if (drain_i) begin
        valid_o <= 1'b0;
      end
      if (wr_i && !clear_i) begin
        pc_o    <= wr_pc_i;
        instr_o <= wr_instr_i;
      end
    end
  end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - IF stage: PC generation, single-outstanding imem fetch, IF/ID register
// Ports:
//   clk_i, rstn_i               clock, asynchronous active-low reset
//   stallF_i                    hold the IF/ID register and the fetch buffer
//   flushD_i                    load a NOP bubble into IF/ID
//   redirect_i, redirect_pc_i   taken branch/jump from execute and its target
//   imem_req_o, imem_addr_o     fetch request (always accepted) and address
//   imem_rvalid_i, imem_rdata_i response strobe and instruction word
//   pcD_o, instrD_o             IF/ID pc and instruction
//   tb_update_o                 IF/ID holds a real fetched instruction
module fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            stallF_i,
  input  logic            flushD_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] pcD_o,
  output logic [XLEN-1:0] instrD_o,
  output logic            tb_update_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_c;
  logic            buf_wr;
  logic            buf_valid;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_instr;
  logic            drain;

  // The buffered instruction moves into IF/ID this cycle.
  assign drain = buf_valid && !stallF_i && !flushD_i && !redirect_i;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req_c    = 1'b0;
    buf_wr   = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
        end else if (!buf_valid || drain) begin
          // Only fetch when the response is guaranteed a free buffer slot.
          req_c    = 1'b1;
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = F_IDLE;
          if (redirect_i) begin
            pc_d = redirect_pc_i;
          end else begin
            buf_wr = 1'b1;
          end
        end else if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = F_DROP;
        end
      end
      F_DROP: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
        end
        if (imem_rvalid_i) begin
          state_d = F_IDLE;
        end
      end
      default: begin
        state_d = F_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= F_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // F_IDLE with an empty buffer requests combinationally, so gate with reset.
  assign imem_req_o  = req_c && rstn_i;
  assign imem_addr_o = pc_q;

  fetch_buffer u_buf (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wr_i       (buf_wr),
    .wr_pc_i    (req_pc_q),
    .wr_instr_i (imem_rdata_i),
    .drain_i    (drain),
    .clear_i    (redirect_i),
    .valid_o    (buf_valid),
    .pc_o       (buf_pc),
    .instr_o    (buf_instr)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pcD_o       <= RESET_PC;
      instrD_o    <= NOP_INSTR;
      tb_update_o <= 1'b0;
    end else if (flushD_i || redirect_i) begin
      instrD_o    <= NOP_INSTR;
      tb_update_o <= 1'b0;
    end else if (stallF_i) begin
      pcD_o       <= pcD_o;
      instrD_o    <= instrD_o;
      tb_update_o <= tb_update_o;
    end else if (buf_valid) begin
      pcD_o       <= buf_pc;
      instrD_o    <= buf_instr;
      tb_update_o <= 1'b1;
    end else begin
      instrD_o    <= NOP_INSTR;
      tb_update_o <= 1'b0;
    end
  end

  a_no_rvalid_idle: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(state_q == F_IDLE && imem_rvalid_i));

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for the fetch stage
module tb_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] RST = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        stallF_i, flushD_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pcD_o, instrD_o;
  logic        tb_update_o;

  always #5 clk_i = ~clk_i;

  fetch #(.RESET_PC(RST)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .stallF_i(stallF_i), .flushD_i(flushD_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pcD_o(pcD_o), .instrD_o(instrD_o), .tb_update_o(tb_update_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what IF/ID must show next cycle and what fetch may do now.
  logic [31:0] m_pcD, m_instr;
  logic        m_tb;
  logic        held, outstanding, stale;
  logic [31:0] held_pc, out_pc, exp_req_pc;
  int          n_deliv = 0;

  // Memory: answers each request after lat cycles with addr ^ KEY.
  int          lat = 1;
  logic        pending = 1'b0;
  int          cnt;
  logic [31:0] maddr;
  logic        rv_nxt = 1'b0;
  logic [31:0] rd_nxt = '0;

  // Per-cycle log of DUT outputs for the directed literal checks.
  int          cyc = 0;
  logic        lg_tb  [256];
  logic        lg_req [256];
  logic [31:0] lg_pc  [256];
  logic [31:0] lg_ins [256];
  logic [31:0] lg_addr[256];

  always @(posedge clk_i) begin
    #1;
    imem_rvalid_i = rv_nxt;
    imem_rdata_i  = rd_nxt;
  end

  always @(negedge clk_i) begin
    logic take, want_req;
    if (!rstn_i) begin
      m_pcD = RST; m_instr = NOP; m_tb = 1'b0;
      held = 1'b0; outstanding = 1'b0; stale = 1'b0;
      held_pc = '0; out_pc = '0; exp_req_pc = RST;
      pending = 1'b0; rv_nxt = 1'b0; cyc = 0;
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_pcD", pcD_o, RST);
      chk("rst_instrD", instrD_o, NOP);
      chk("rst_tb_update", 32'(tb_update_o), 32'd0);
    end else begin
      if (cyc < 256) begin
        lg_tb[cyc] = tb_update_o; lg_req[cyc] = imem_req_o;
        lg_pc[cyc] = pcD_o; lg_ins[cyc] = instrD_o; lg_addr[cyc] = imem_addr_o;
      end
      cyc++;
      chk("ifid_pc", pcD_o, m_pcD);
      chk("ifid_instr", instrD_o, m_instr);
      chk("ifid_tb_update", 32'(tb_update_o), 32'(m_tb));

      take     = held && !stallF_i && !flushD_i && !redirect_i;
      want_req = !outstanding && !redirect_i && (!held || take);
      chk("imem_req", 32'(imem_req_o), 32'(want_req));
      if (imem_req_o) chk("imem_addr", imem_addr_o, exp_req_pc);

      if (flushD_i || redirect_i) begin
        m_instr = NOP; m_tb = 1'b0;
      end else if (stallF_i) begin
        m_tb = m_tb;
      end else if (held) begin
        m_pcD = held_pc; m_instr = held_pc ^ KEY; m_tb = 1'b1;
        held = 1'b0; n_deliv++;
      end else begin
        m_instr = NOP; m_tb = 1'b0;
      end
      if (imem_rvalid_i) begin
        if (outstanding && !stale && !redirect_i) begin
          held = 1'b1; held_pc = out_pc;
        end
        outstanding = 1'b0; stale = 1'b0;
      end
      if (redirect_i) begin
        held = 1'b0;
        if (outstanding) stale = 1'b1;
        exp_req_pc = redirect_pc_i;
      end
      if (want_req) begin
        outstanding = 1'b1; stale = 1'b0; out_pc = exp_req_pc;
        exp_req_pc = exp_req_pc + 32'd4;
      end

      if (imem_rvalid_i) begin rv_nxt = 1'b0; pending = 1'b0; end
      if (imem_req_o) begin pending = 1'b1; cnt = lat; maddr = imem_addr_o; end
      if (pending && !rv_nxt) begin
        cnt--;
        if (cnt <= 0) begin rv_nxt = 1'b1; rd_nxt = maddr ^ KEY; end
      end
    end
  end

  task automatic nxt(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int l);
    @(posedge clk_i); #1;
    rstn_i = 1'b0; stallF_i = 1'b0; flushD_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; lat = l;
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
  endtask

  bit          t1_tb  [14] = '{0,0,0,1,0,1,1,1,1,1,0,1,0,1};
  bit          t1_req [14] = '{1,0,1,0,1,0,0,0,1,0,1,0,1,0};
  logic [31:0] t1_pc  [14] = '{RST, RST, RST, RST, RST,
                               32'h8000_0004, 32'h8000_0004, 32'h8000_0004, 32'h8000_0004,
                               32'h8000_0008, 32'h8000_0008, 32'h8000_000C, 32'h8000_000C,
                               32'h8000_0010};
  logic [31:0] t1_addr[14] = '{RST, 0, 32'h8000_0004, 0, 32'h8000_0008, 0, 0, 0,
                               32'h8000_000C, 0, 32'h8000_0010, 0, 32'h8000_0014, 0};

  initial begin
    int d0;
    rstn_i = 1'b0; stallF_i = 1'b0; flushD_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

    // Streaming at latency 1 with a 3-cycle stall while the buffer is full.
    do_reset(1);
    nxt(5); stallF_i = 1'b1;
    nxt(3); stallF_i = 1'b0;
    nxt(6);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("t1_tb[%0d]", i), 32'(lg_tb[i]), 32'(t1_tb[i]));
      chk($sformatf("t1_pc[%0d]", i), lg_pc[i], t1_pc[i]);
      chk($sformatf("t1_instr[%0d]", i), lg_ins[i], t1_tb[i] ? (t1_pc[i] ^ KEY) : NOP);
      chk($sformatf("t1_req[%0d]", i), 32'(lg_req[i]), 32'(t1_req[i]));
      if (t1_req[i]) chk($sformatf("t1_addr[%0d]", i), lg_addr[i], t1_addr[i]);
    end

    // Redirect while waiting (latency 4): stale response dropped.
    do_reset(4);
    nxt(1); redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    nxt(1); redirect_i = 1'b0;
    nxt(11);
    chk("t3_first_addr", lg_addr[0], RST);
    for (int i = 1; i < 5; i++) chk($sformatf("t3_noreq[%0d]", i), 32'(lg_req[i]), 32'd0);
    chk("t3_req5", 32'(lg_req[5]), 32'd1);
    chk("t3_addr5", lg_addr[5], 32'h8000_0100);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t3_bubble_tb[%0d]", i), 32'(lg_tb[i]), 32'd0);
      chk($sformatf("t3_bubble_ins[%0d]", i), lg_ins[i], NOP);
    end
    chk("t3_tb11", 32'(lg_tb[11]), 32'd1);
    chk("t3_pc11", lg_pc[11], 32'h8000_0100);
    chk("t3_ins11", lg_ins[11], 32'h25A5_0100);

    // Two redirects back to back while a request is outstanding: latest wins.
    do_reset(4);
    nxt(1); redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    nxt(1); redirect_pc_i = 32'h8000_0300;
    nxt(1); redirect_i = 1'b0;
    nxt(10);
    for (int i = 0; i < 13; i++)
      chk($sformatf("t4_no0200[%0d]", i), 32'(lg_req[i] && lg_addr[i] == 32'h8000_0200), 32'd0);
    chk("t4_req5", 32'(lg_req[5]), 32'd1);
    chk("t4_addr5", lg_addr[5], 32'h8000_0300);
    chk("t4_pc11", lg_pc[11], 32'h8000_0300);

    // flush + redirect while the buffer is full.
    do_reset(1);
    nxt(2); flushD_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0400;
    nxt(1); flushD_i = 1'b0; redirect_i = 1'b0;
    nxt(5);
    chk("t5_noreq2", 32'(lg_req[2]), 32'd0);
    chk("t5_ins3", lg_ins[3], NOP);
    chk("t5_tb3", 32'(lg_tb[3]), 32'd0);
    chk("t5_addr3", lg_addr[3], 32'h8000_0400);
    chk("t5_tb5", 32'(lg_tb[5]), 32'd0);
    chk("t5_pc6", lg_pc[6], 32'h8000_0400);
    chk("t5_tb6", 32'(lg_tb[6]), 32'd1);

    // Asynchronous reset while waiting on the fetch after 8000_0040.
    do_reset(1);
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0040;
    nxt(1); redirect_i = 1'b0;
    nxt(2); lat = 4;
    nxt(1);
    chk("t6_pre_pc", pcD_o, 32'h8000_0040);
    chk("t6_pre_tb", 32'(tb_update_o), 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("t6_async_req", 32'(imem_req_o), 32'd0);
    chk("t6_async_pc", pcD_o, RST);
    chk("t6_async_ins", instrD_o, NOP);
    chk("t6_async_tb", 32'(tb_update_o), 32'd0);
    lat = 1;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    nxt(3);
    chk("t6_first_req", 32'(lg_req[0]), 32'd1);
    chk("t6_first_addr", lg_addr[0], RST);

    // PC wrap.
    do_reset(1);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    nxt(1); redirect_i = 1'b0;
    nxt(5);
    chk("t7_addr1", lg_addr[1], 32'hFFFF_FFFC);
    chk("t7_req3", 32'(lg_req[3]), 32'd1);
    chk("t7_addr3", lg_addr[3], 32'h0000_0000);
    chk("t7_pc4", lg_pc[4], 32'hFFFF_FFFC);
    chk("t7_ins4", lg_ins[4], 32'h5A5A_FFFC);

    // Randomised traffic checked cycle by cycle against the model.
    do_reset(1);
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      stallF_i   = ($urandom_range(0, 99) < 25);
      flushD_i   = ($urandom_range(0, 99) < 6);
      redirect_i = ($urandom_range(0, 99) < 7);
      redirect_pc_i = ($urandom_range(0, 9) < 3) ? $urandom
                    : (RST + ($urandom_range(0, 255) << 2));
      lat = $urandom_range(1, 4);
      nxt(1);
    end
    stallF_i = 1'b0; flushD_i = 1'b0; redirect_i = 1'b0;
    nxt(10);
    chk("rand_progress", 32'(n_deliv - d0 > 150), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
